// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store front end for a word-organised data RAM
//
// Purpose: turns byte/half/word load and store requests into word accesses on
// data_RAM. Loads are sign- or zero-extended. Sub-word stores are done as
// read-modify-write. Misaligned and reserved-size requests return an error
// without touching the RAM.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write, req_size        store/load, 00 byte 01 half 10 word 11 reserved
//   req_unsigned               load zero-extend (1) or sign-extend (0)
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_error     load result and error flag, valid with resp_valid
//   ram_addr, ram_we           word address and write enable to data_RAM
//   ram_wdata, ram_rdata       write word and asynchronous read word

module load_store_unit #(
  parameter int ADDR_WIDTH = 18,
  parameter int RAM_AW     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                error_q, error_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;

  logic                req_err;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [31:0]         load_ext;
  logic [31:0]         store_word;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  // Little-endian lane extraction from the RAM word for loads.
  always_comb begin
    load_byte = ram_rdata[{lane_q, 3'b000} +: 8];
    load_half = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = {{16{~uns_q & load_half[15]}}, load_half};
      default: load_ext = ram_rdata;
    endcase
  end

  // Word written in WRITE: the store data itself, or the word read in READ
  // with only the addressed lane replaced.
  always_comb begin
    store_word = merge_q;
    case (size_q)
      SZ_BYTE: store_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: begin
        if (lane_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rdata_q    <= 32'h0;
      error_q    <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          error_d = req_err;
          rdata_d = 32'h0;
          if (req_err) begin
            // ram_addr is left alone so erroring requests never move the RAM port.
            state_d = S_RESP;
          end else begin
            ram_addr_d = req_addr[ADDR_WIDTH-1:2];
            state_d = (req_write && req_size == SZ_WORD) ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        if (write_q) begin
          merge_d = ram_rdata;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // ram_we is decoded straight from state so an asynchronous reset during
  // WRITE removes it before the next edge.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    ram_we     = (state_q == S_WRITE);
    ram_wdata  = (state_q == S_WRITE) ? store_word : 32'h0;
    ram_addr   = ram_addr_q;
    resp_rdata = rdata_q;
    resp_error = error_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ADDR_WIDTH(18), .RAM_AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to its response and check latency, error,
  // load data and the RAM writes seen on the way.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [17:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd,
                        input int exp_w, input logic [31:0] exp_wd);
    int lat;
    int wcnt;
    logic [31:0] wa;
    logic [31:0] wdv;
    wcnt = 0;
    wa   = '0;
    wdv  = '0;
    check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (ram_we) begin
        wcnt++;
        wa  = {16'b0, ram_addr};
        wdv = ram_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":error"}, {31'b0, resp_error}, {31'b0, exp_err});
    if (chk_rd) check({tag, ":rdata"}, resp_rdata, exp_rd);
    check({tag, ":writes"}, wcnt, exp_w);
    if (exp_w > 0) begin
      check({tag, ":ram_addr"}, wa, {16'b0, a[17:2]});
      check({tag, ":ram_wdata"}, wdv, exp_wd);
    end
    @(posedge clk); #1;
    check({tag, ":pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ":ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  logic [17:0] hs_addr [3];
  logic [1:0]  hs_size [3];
  logic        hs_uns  [3];
  logic [31:0] hs_exp  [3];

  initial begin
    int idx;
    int ridx;
    int cyc;
    logic fire;

    #12;
    check("rst:req_ready", {31'b0, req_ready}, 32'd1);
    check("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst:ram_we", {31'b0, ram_we}, 32'd0);
    check("rst:ram_addr", {16'b0, ram_addr}, 32'd0);
    check("rst:ram_wdata", ram_wdata, 32'd0);
    check("rst:resp_rdata", resp_rdata, 32'd0);
    check("rst:resp_error", {31'b0, resp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word store then word load
    do_req("sw", 1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0, 1, 32'hDEADBEEF);
    do_req("lw", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF, 0, 32'h0);

    // byte read-modify-write
    do_req("sb", 1'b1, 2'b00, 1'b0, 18'h00012, 32'h000000AA, 3, 1'b0, 1'b0, 32'h0, 1, 32'hDEAABEEF);

    // extension on loads
    do_req("lb",  1'b0, 2'b00, 1'b0, 18'h00013, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFFDE, 0, 32'h0);
    do_req("lbu", 1'b0, 2'b00, 1'b1, 18'h00013, 32'h0, 2, 1'b0, 1'b1, 32'h000000DE, 0, 32'h0);
    do_req("lh",  1'b0, 2'b01, 1'b0, 18'h00010, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFBEEF, 0, 32'h0);
    do_req("lhu", 1'b0, 2'b01, 1'b1, 18'h00012, 32'h0, 2, 1'b0, 1'b1, 32'h0000DEAA, 0, 32'h0);
    do_req("lbu1", 1'b0, 2'b00, 1'b1, 18'h00011, 32'h0, 2, 1'b0, 1'b1, 32'h000000BE, 0, 32'h0);

    // half store into the upper lane
    do_req("sh", 1'b1, 2'b01, 1'b0, 18'h00012, 32'h00001234, 3, 1'b0, 1'b0, 32'h0, 1, 32'h1234BEEF);
    do_req("lw2", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 2, 1'b0, 1'b1, 32'h1234BEEF, 0, 32'h0);

    // errors
    do_req("err_lw", 1'b0, 2'b10, 1'b0, 18'h00011, 32'h0, 1, 1'b1, 1'b1, 32'h0, 0, 32'h0);
    do_req("err_sh", 1'b1, 2'b01, 1'b0, 18'h00013, 32'h5555, 1, 1'b1, 1'b1, 32'h0, 0, 32'h0);
    do_req("err_sz", 1'b0, 2'b11, 1'b0, 18'h00010, 32'h0, 1, 1'b1, 1'b1, 32'h0, 0, 32'h0);
    do_req("lw3", 1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 2, 1'b0, 1'b1, 32'h1234BEEF, 0, 32'h0);

    // back-to-back loads with req_valid held high
    hs_addr[0] = 18'h00010; hs_size[0] = 2'b10; hs_uns[0] = 1'b0; hs_exp[0] = 32'h1234BEEF;
    hs_addr[1] = 18'h00013; hs_size[1] = 2'b00; hs_uns[1] = 1'b0; hs_exp[1] = 32'h00000012;
    hs_addr[2] = 18'h00010; hs_size[2] = 2'b01; hs_uns[2] = 1'b0; hs_exp[2] = 32'hFFFFBEEF;
    idx = 0;
    ridx = 0;
    req_write = 1'b0; req_wdata = '0;
    req_addr = hs_addr[0]; req_size = hs_size[0]; req_unsigned = hs_uns[0];
    req_valid = 1'b1;
    for (cyc = 0; cyc < 40 && !(idx == 3 && ridx == 3); cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (ridx < 3) check($sformatf("hs:rdata%0d", ridx), resp_rdata, hs_exp[ridx]);
        ridx++;
      end
      fire = req_valid & req_ready;
      @(posedge clk); #1;
      if (fire) begin
        idx++;
        if (idx < 3) begin
          req_addr = hs_addr[idx]; req_size = hs_size[idx]; req_unsigned = hs_uns[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("hs:accepted", idx, 3);
    check("hs:responses", ridx, 3);

    // reset in the middle of a word store
    do_req("sw20", 1'b1, 2'b10, 1'b0, 18'h00020, 32'h11111111, 2, 1'b0, 1'b0, 32'h0, 1, 32'h11111111);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 18'h00020; req_wdata = 32'h22222222; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid:ram_we_before", {31'b0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid:ram_we", {31'b0, ram_we}, 32'd0);
    check("mid:req_ready", {31'b0, req_ready}, 32'd1);
    check("mid:resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("mid:no_pulse", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("lw20", 1'b0, 2'b10, 1'b0, 18'h00020, 32'h0, 2, 1'b0, 1'b1, 32'h11111111, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
